// File: rtl/unified_mem_arb.sv
// Shared single-port memory with fetch/data channel arbitration.
// Alternating grant, multi-cycle access, byte/half/word load-store.
module unified_mem_arb #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic [XLEN-1:0] i_rdata,
  output logic            i_valid,
  output logic            i_stall,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [1:0]      d_size,
  input  logic            d_unsigned,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_valid,
  output logic            d_misaligned,
  output logic            d_stall
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int NB = XLEN / 8;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state, state_nx;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  logic            gnt_d, last_d;
  logic [AW-1:0]   idx;
  logic [1:0]      lane, size;
  logic            we, uns;
  logic [XLEN-1:0] wdata;
  logic [CW-1:0]   cnt;

  logic            take, pick_d, commit, mis;
  logic [XLEN-1:0] word, sh, ld_val, wd;
  logic [7:0]      byt;
  logic [15:0]     hw;
  logic [NB-1:0]   be;

  logic unused_ok;
  assign unused_ok = ^{i_addr[XLEN-1:AW+2], i_addr[1:0],
                       d_addr[XLEN-1:AW+2]};

  assign i_stall = i_req & ~i_valid;
  assign d_stall = d_req & ~d_valid;
  assign pick_d  = d_req & (~i_req | ~last_d);

  always_comb begin
    state_nx = state;
    take     = 1'b0;
    commit   = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_req | d_req) begin
          take     = 1'b1;
          state_nx = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          commit   = 1'b1;
          state_nx = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Lane steering for loads and byte enables for stores
  always_comb begin
    word   = mem[idx];
    sh     = word >> {lane, 3'b000};
    byt    = sh[7:0];
    hw     = lane[1] ? word[16 +: 16] : word[15:0];
    mis    = 1'b0;
    ld_val = word;
    be     = '1;
    wd     = wdata;
    unique case (1'b1)
      (size == 2'b00): begin
        ld_val = {{(XLEN-8){~uns & byt[7]}}, byt};
        be     = NB'(1) << lane;
        wd     = {NB{wdata[7:0]}};
      end
      (size == 2'b01): begin
        mis    = lane[0];
        ld_val = {{(XLEN-16){~uns & hw[15]}}, hw};
        be     = NB'(3) << {lane[1], 1'b0};
        wd     = {(NB/2){wdata[15:0]}};
      end
      size[1]: mis = |lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && commit && we && !mis) begin
      for (int k = 0; k < NB; k++) begin
        if (be[k]) mem[idx][8*k +: 8] <= wd[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_d       <= 1'b0;
      gnt_d        <= 1'b0;
      cnt          <= '0;
      i_valid      <= 1'b0;
      d_valid      <= 1'b0;
      d_misaligned <= 1'b0;
      i_rdata      <= '0;
      d_rdata      <= '0;
    end else begin
      i_valid      <= 1'b0;
      d_valid      <= 1'b0;
      d_misaligned <= 1'b0;
      if (take) begin
        gnt_d  <= pick_d;
        last_d <= pick_d;
        cnt    <= CW'(LATENCY - 1);
        idx    <= pick_d ? d_addr[AW+1:2] : i_addr[AW+1:2];
        lane   <= pick_d ? d_addr[1:0] : 2'b00;
        size   <= pick_d ? d_size : 2'b10;
        we     <= pick_d & d_we;
        uns    <= d_unsigned;
        wdata  <= d_wdata;
      end
      if (state == ACCESS && cnt != '0) cnt <= cnt - CW'(1);
      if (commit) begin
        if (gnt_d) begin
          d_valid      <= 1'b1;
          d_misaligned <= mis;
          d_rdata      <= mis ? '0 : ld_val;
        end else begin
          i_valid <= 1'b1;
          i_rdata <= word;
        end
      end
    end
  end
endmodule
